// File: rtl/mem_read_burst_ctrl_pkg.sv
// Shared definitions for the memory-side read-burst controller and its helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: controller state encoding, AXI burst type and AXI transfer-size helper.
package mem_read_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // AXI ARBURST encoding for incrementing bursts, the only kind this controller issues.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI ARSIZE for a beat of data_bits; also the word-to-byte address shift.
  function automatic int axi_size(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction

endpackage

// File: rtl/mem_burst_split.sv
// Splits a remaining request into the next AXI burst length that stays inside one aligned window.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the result.
// Ports: cur (current word address), rem (words still to fetch) -> chunk (beats for the next burst, 1..MAX_AXI_BEATS when rem != 0).
module mem_burst_split #(
  parameter int ADDR_BITS     = 23,
  parameter int BUSRT_BITS    = 10,
  parameter int MAX_AXI_BEATS = 64
) (
  input  logic [ADDR_BITS-1:0]  cur,
  input  logic [BUSRT_BITS-1:0] rem,
  output logic [8:0]            chunk
);

  localparam int LOG_MAX = $clog2(MAX_AXI_BEATS);

  logic [8:0] room;
  logic       unused_cur_hi;

  // Words left before the next aligned MAX_AXI_BEATS boundary.
  assign room          = 9'(MAX_AXI_BEATS) - 9'(cur[LOG_MAX-1:0]);
  assign unused_cur_hi = ^cur[ADDR_BITS-1:LOG_MAX];

  // rem is only narrowed to 9 bits when it is below room, so it always fits.
  assign chunk = (32'(rem) < 32'(room)) ? 9'(rem) : room;

endmodule

// File: rtl/mem_read_burst_ctrl.sv
// Memory-side responder: turns one word-addressed read request into aligned AXI4 INCR bursts, one AR outstanding.
// Latency: request -> ARVALID next cycle; R handshake k -> data_valid k+1; final beat k -> finish k+2.
// Backpressure: AR waits on m_arready; R is always accepted in DATA; no backpressure toward the arbiter.
// Ports: mem_clk/rst_n (sync, active low); rd_burst_* request/return side; m_ar*/m_r* AXI4 read channels;
//        busy (not idle); err (sticky: bad rresp, rlast mismatch or timeout).
module mem_read_burst_ctrl #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BUSRT_BITS    = 10,
  parameter int AXI_ADDR_BITS = 32,
  parameter int MAX_AXI_BEATS = 64,
  parameter int TIMEOUT       = 8000
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     rd_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  output logic [AXI_ADDR_BITS-1:0] m_araddr,
  output logic [7:0]               m_arlen,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [MEM_DATA_BITS-1:0] m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  output logic                     busy,
  output logic                     err
);

  import mem_read_burst_ctrl_pkg::*;

  localparam int SHIFT = axi_size(MEM_DATA_BITS);
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_t                state, state_n;
  logic [ADDR_BITS-1:0]  cur;
  logic [BUSRT_BITS-1:0] rem;
  logic [BUSRT_BITS-1:0] beat_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [8:0]            chunk;
  logic                  beat;
  logic                  bound;
  logic                  last_beat;
  logic                  tmo_hit;

  mem_burst_split #(
    .ADDR_BITS     (ADDR_BITS),
    .BUSRT_BITS    (BUSRT_BITS),
    .MAX_AXI_BEATS (MAX_AXI_BEATS)
  ) u_split (
    .cur   (cur),
    .rem   (rem),
    .chunk (chunk)
  );

  assign beat      = (state == ST_DATA) && m_rvalid;
  assign bound     = (beat_cnt == BUSRT_BITS'(1));
  // A premature rlast still closes the burst so the slave and controller stay in step.
  assign last_beat = beat && (m_rlast || bound);
  assign tmo_hit   = (state == ST_DATA) && !m_rvalid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_n   = state;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_rready  = 1'b0;
    case (state)
      ST_IDLE: begin
        // The finish cycle itself is still IDLE; holding off here keeps a new request
        // from being taken before the arbiter has seen finish.
        if (rd_burst_req && (rd_burst_len != '0) && !rd_burst_finish) state_n = ST_AR;
      end
      ST_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = AXI_ADDR_BITS'(cur) << SHIFT;
        m_arlen   = 8'(chunk - 9'd1);
        if (m_arready) state_n = ST_DATA;
      end
      ST_DATA: begin
        m_rready = 1'b1;
        if (last_beat)    state_n = (rem != '0) ? ST_AR : ST_DONE;
        else if (tmo_hit) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      cur                 <= '0;
      rem                 <= '0;
      beat_cnt            <= '0;
      tmo_cnt             <= '0;
      rd_burst_data_valid <= 1'b0;
      rd_burst_data       <= '0;
      rd_burst_finish     <= 1'b0;
      err                 <= 1'b0;
    end else begin
      state               <= state_n;
      rd_burst_data_valid <= beat;
      if (beat) rd_burst_data <= m_rdata;
      // Registering finish off DONE puts it two cycles after the final beat.
      rd_burst_finish     <= (state == ST_DONE);
      if ((beat && ((m_rresp != 2'b00) || (m_rlast != bound))) || tmo_hit) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (state_n == ST_AR) begin
            rem <= rd_burst_len;
            cur <= rd_burst_addr;
          end
        end
        ST_AR: begin
          if (m_arready) begin
            cur      <= cur + ADDR_BITS'(chunk);
            rem      <= rem - BUSRT_BITS'(chunk);
            beat_cnt <= BUSRT_BITS'(chunk);
            tmo_cnt  <= '0;
          end
        end
        ST_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt - BUSRT_BITS'(1);
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_burst_ctrl.sv
// Self-checking bench for mem_read_burst_ctrl: randomized AXI slave plus a request-level reference model.
// Latency: n/a.
// Backpressure: slave randomizes arready/rvalid gaps.
module tb_mem_read_burst_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 23;
  localparam int BW   = 10;
  localparam int XW   = 32;
  localparam int MAXB = 64;
  localparam int TMO  = 8000;

  logic          mem_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_burst_req = 1'b0;
  logic [BW-1:0] rd_burst_len = '0;
  logic [AW-1:0] rd_burst_addr = '0;
  logic          rd_burst_data_valid;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_finish;
  logic [XW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 1'b0;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
  logic          busy;
  logic          err;

  mem_read_burst_ctrl #(
    .MEM_DATA_BITS (DW), .ADDR_BITS (AW), .BUSRT_BITS (BW),
    .AXI_ADDR_BITS (XW), .MAX_AXI_BEATS (MAXB), .TIMEOUT (TMO)
  ) dut (
    .mem_clk (mem_clk), .rst_n (rst_n),
    .rd_burst_req (rd_burst_req), .rd_burst_len (rd_burst_len), .rd_burst_addr (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid), .rd_burst_data (rd_burst_data),
    .rd_burst_finish (rd_burst_finish),
    .m_araddr (m_araddr), .m_arlen (m_arlen), .m_arvalid (m_arvalid), .m_arready (m_arready),
    .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rlast (m_rlast), .m_rvalid (m_rvalid),
    .m_rready (m_rready), .busy (busy), .err (err)
  );

  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // observations
  int          ar_addr_q[$];
  int          ar_len_q[$];
  logic [31:0] words[$];
  int          n_fin, fin_cyc, last_hs, last_dv, ar_hs, hold_bad;
  // slave state and knobs
  int          r_addr = 0, r_left = 0, glob_beat = 0;
  int          ar_low = 0, rresp_bad = -1, early_last = -1, rv_pct = 100, ar_pct = 100;
  bit          stall_r = 1'b0;
  int          hold_cnt, stab_bad;
  bit          hold_seen;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // One clock: sample DUT outputs at the falling edge, then drive slave inputs for the next rising edge.
  task automatic tick();
    bit last;
    @(negedge mem_clk);
    if (rd_burst_data_valid) begin
      words.push_back(rd_burst_data);
      last_dv = cyc;
    end else if (words.size() > 0 && rd_burst_data != words[$]) begin
      hold_bad++;
    end
    if (rd_burst_finish) begin
      n_fin++;
      fin_cyc = cyc;
    end
    if (ar_low > 0) begin
      if (rd_burst_data_valid) stab_bad++;
      if (m_arvalid) begin
        hold_cnt++;
        if (!hold_seen) begin
          hold_seen = 1'b1;
          hold_addr = m_araddr;
          hold_len  = m_arlen;
        end else if (m_araddr != hold_addr || m_arlen != hold_len) begin
          stab_bad++;
        end
      end
      m_arready = 1'b0;
      ar_low--;
    end else begin
      m_arready = (int'($urandom_range(99)) < ar_pct);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
    m_rdata  = $urandom;
    if (r_left > 0 && !stall_r && int'($urandom_range(99)) < rv_pct) begin
      last     = (r_left == 1) || (glob_beat == early_last);
      m_rvalid = 1'b1;
      m_rdata  = mem_word(r_addr);
      m_rlast  = last;
      if (glob_beat == rresp_bad) m_rresp = 2'b10;
      if (m_rready) begin
        last_hs = cyc;
        glob_beat++;
        r_addr = (r_addr + 1) & ((1 << AW) - 1);
        r_left = last ? 0 : r_left - 1;
      end
    end
    if (m_arvalid && m_arready) begin
      ar_hs = cyc;
      ar_addr_q.push_back(int'(m_araddr >> 2));
      ar_len_q.push_back(int'(m_arlen) + 1);
      r_addr = int'(m_araddr >> 2);
      r_left = int'(m_arlen) + 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    r_left = 0;
    words.delete();
  endtask

  // Issue one request and compare against the request-level model: burst list from
  // min(remaining, room to the next 64-word boundary), words = mem[addr .. addr+exp_n-1].
  task automatic run_req(input string tag, input int addr, input int len, input int exp_n,
                         input bit exp_err, input bit exp_tmo);
    int cur, rem, ch;
    int e_addr[$];
    int e_len[$];
    cur = addr;
    rem = len;
    while (rem > 0) begin
      ch = MAXB - (cur % MAXB);
      if (rem < ch) ch = rem;
      e_addr.push_back(cur);
      e_len.push_back(ch);
      cur = (cur + ch) % (1 << AW);
      rem -= ch;
    end
    words.delete();
    ar_addr_q.delete();
    ar_len_q.delete();
    n_fin = 0; glob_beat = 0; hold_bad = 0;
    last_hs = -100; last_dv = -100; fin_cyc = -100; ar_hs = -100;
    rd_burst_req  = 1'b1;
    rd_burst_addr = AW'(addr);
    rd_burst_len  = BW'(len);
    for (int i = 0; i < TMO + 3000 && n_fin == 0; i++) begin
      tick();
      if (words.size() > 0 || n_fin > 0) rd_burst_req = 1'b0;
    end
    rd_burst_req = 1'b0;
    repeat (4) tick();
    chk({tag, ".finish_count"}, n_fin, 1);
    chk({tag, ".ar_count"}, ar_addr_q.size(), e_addr.size());
    for (int k = 0; k < e_addr.size() && k < ar_addr_q.size(); k++) begin
      chk({tag, ".ar_addr"}, ar_addr_q[k], e_addr[k]);
      chk({tag, ".ar_len"}, ar_len_q[k], e_len[k]);
    end
    chk({tag, ".word_count"}, words.size(), exp_n);
    for (int k = 0; k < exp_n && k < words.size(); k++)
      chk({tag, ".word"}, words[k], mem_word((addr + k) & ((1 << AW) - 1)));
    if (exp_tmo) begin
      chk({tag, ".tmo_latency"}, fin_cyc - ar_hs, TMO + 2);
    end else begin
      chk({tag, ".dv_latency"}, last_dv - last_hs, 1);
      chk({tag, ".fin_latency"}, fin_cyc - last_hs, 2);
    end
    chk({tag, ".data_hold"}, hold_bad, 0);
    chk({tag, ".err"}, err, exp_err);
    chk({tag, ".busy_after"}, busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data_valid"}, rd_burst_data_valid, 0);
    chk({tag, ".data"}, rd_burst_data, 0);
    chk({tag, ".finish"}, rd_burst_finish, 0);
    chk({tag, ".arvalid"}, m_arvalid, 0);
    chk({tag, ".araddr"}, m_araddr, 0);
    chk({tag, ".arlen"}, m_arlen, 0);
    chk({tag, ".rready"}, m_rready, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  initial begin
    int busy_seen;
    int a, l;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_req("len16", 0, 16, 16, 0, 0);
    run_req("len100", 'h3C, 100, 100, 0, 0);

    ar_low = 20; hold_cnt = 0; stab_bad = 0; hold_seen = 1'b0;
    run_req("arhold", 'h10, 8, 8, 0, 0);
    chk("arhold.cycles", hold_cnt, 20);
    chk("arhold.stable", stab_bad, 0);

    busy_seen = 0;
    ar_addr_q.delete();
    rd_burst_req = 1'b1; rd_burst_len = '0; rd_burst_addr = AW'(5);
    repeat (6) begin
      tick();
      if (busy) busy_seen++;
    end
    rd_burst_req = 1'b0;
    chk("len0.busy", busy_seen, 0);
    chk("len0.ar_count", ar_addr_q.size(), 0);

    for (int t = 0; t < 12; t++) begin
      rv_pct = int'($urandom_range(100, 40));
      ar_pct = int'($urandom_range(100, 30));
      l = int'($urandom_range(200, 1));
      if (t % 4 == 0) a = (1 << AW) - int'($urandom_range(100, 1));
      else            a = int'($urandom_range((1 << AW) - 1));
      run_req("rand", a, l, l, 0, 0);
    end
    rv_pct = 100;
    ar_pct = 100;

    do_reset();
    rresp_bad = 4;
    run_req("rresp", 'h40, 8, 8, 1, 0);
    rresp_bad = -1;

    do_reset();
    early_last = 2;
    run_req("early_rlast", 'h100, 8, 3, 1, 0);
    early_last = -1;

    do_reset();
    stall_r = 1'b1;
    run_req("timeout", 'h200, 8, 0, 1, 1);
    stall_r = 1'b0;
    r_left  = 0;

    do_reset();
    rresp_bad = 1;
    words.delete();
    rd_burst_req = 1'b1; rd_burst_addr = '0; rd_burst_len = BW'(40);
    for (int i = 0; i < 500 && words.size() < 5; i++) begin
      tick();
      if (words.size() > 0) rd_burst_req = 1'b0;
    end
    rd_burst_req = 1'b0;
    chk("midrst.err_before", err, 1);
    rst_n = 1'b0;
    words.delete();
    tick();
    chk_all_zero("midrst");
    rst_n     = 1'b1;
    r_left    = 0;
    rresp_bad = -1;
    run_req("after_rst", 'h123, 4, 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
